// File: rtl/tmr_vote_ctrl.sv
// Triple-redundancy vote controller: retires a channel after THRESH consecutive minority votes, then votes 2-of-2.
// All outputs registered, 1 cycle from the en sample; no backpressure, one sample per en strobe.
module tmr_vote_ctrl #(
    parameter int THRESH = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       en,
    input  logic       a,
    input  logic       b,
    input  logic       c,
    input  logic       clr_fault,
    output logic       y,
    output logic       y_valid,
    output logic       mismatch,
    output logic [2:0] fault,
    output logic [1:0] state,
    output logic       err
);
    localparam int CW = $clog2(THRESH + 1);
    localparam logic [CW-1:0] THR_C = CW'(THRESH);

    typedef enum logic [1:0] {
        ST_NORMAL   = 2'b00,
        ST_DEGRADED = 2'b01,
        ST_FAILED   = 2'b10
    } state_e;

    state_e          state_q;
    logic            y_q;
    logic            y_valid_q;
    logic            mismatch_q;
    logic [2:0]      fault_q;
    logic            err_q;
    logic [CW-1:0]   cnt_q [3];
    logic [CW-1:0]   cnt_d [3];

    logic [2:0]      ch;
    logic            maj;
    logic [2:0]      minor;
    logic [2:0]      hit;
    logic [1:0]      sv;

    // Bit 2 is channel a throughout, matching the fault vector layout.
    assign ch    = {a, b, c};
    assign maj   = (a & b) | (a & c) | (b & c);
    assign minor = ch ^ {3{maj}};

    always_comb begin
        for (int i = 0; i < 3; i++) begin
            cnt_d[i] = '0;
            if (minor[i]) begin
                cnt_d[i] = (cnt_q[i] == THR_C) ? cnt_q[i] : cnt_q[i] + 1'b1;
            end
            hit[i] = minor[i] && (cnt_d[i] == THR_C);
        end
    end

    always_comb begin
        case (fault_q)
            3'b100:  sv = {b, c};
            3'b010:  sv = {a, c};
            default: sv = {a, b};
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= ST_NORMAL;
            y_q        <= 1'b0;
            y_valid_q  <= 1'b0;
            mismatch_q <= 1'b0;
            fault_q    <= 3'b000;
            err_q      <= 1'b0;
            for (int i = 0; i < 3; i++) cnt_q[i] <= '0;
        end else if (clr_fault) begin
            state_q    <= ST_NORMAL;
            y_valid_q  <= 1'b0;
            mismatch_q <= 1'b0;
            fault_q    <= 3'b000;
            err_q      <= 1'b0;
            for (int i = 0; i < 3; i++) cnt_q[i] <= '0;
        end else begin
            y_valid_q <= 1'b0;
            if (en) begin
                case (state_q)
                    ST_NORMAL: begin
                        y_q        <= maj;
                        y_valid_q  <= 1'b1;
                        mismatch_q <= |minor;
                        for (int i = 0; i < 3; i++) cnt_q[i] <= cnt_d[i];
                        if (|hit) begin
                            fault_q <= fault_q | hit;
                            state_q <= ST_DEGRADED;
                        end
                    end
                    ST_DEGRADED: begin
                        if (sv[1] == sv[0]) begin
                            y_q        <= sv[0];
                            y_valid_q  <= 1'b1;
                            mismatch_q <= 1'b0;
                        end else begin
                            // Two survivors disagree: no way to tell which one is bad.
                            mismatch_q <= 1'b1;
                            err_q      <= 1'b1;
                            state_q    <= ST_FAILED;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    assign y        = y_q;
    assign y_valid  = y_valid_q;
    assign mismatch = mismatch_q;
    assign fault    = fault_q;
    assign state    = state_q;
    assign err      = err_q;
endmodule

// File: tb/tb_tmr_vote_ctrl.sv
// Scoreboard bench for tmr_vote_ctrl: a behavioural model pushes expected outputs per sample, popped after the edge.
module tb_tmr_vote_ctrl;
    localparam int THRESH = 4;

    logic       clk = 1'b0;
    logic       reset;
    logic       en, a, b, c, clr_fault;
    logic       y, y_valid, mismatch, err;
    logic [2:0] fault;
    logic [1:0] state;

    tmr_vote_ctrl #(.THRESH(THRESH)) u_dut (
        .clk(clk), .reset(reset), .en(en), .a(a), .b(b), .c(c),
        .clr_fault(clr_fault), .y(y), .y_valid(y_valid), .mismatch(mismatch),
        .fault(fault), .state(state), .err(err)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic       y;
        logic       vld;
        logic       mis;
        logic [2:0] fault;
        logic [1:0] st;
        logic       err;
    } exp_t;

    exp_t sb_q[$];
    int   n_chk = 0;
    int   n_err = 0;
    int   n_step = 0;

    // Reference model state
    int         m_cnt [3];
    logic       m_y, m_vld, m_mis, m_err;
    logic [2:0] m_fault;
    logic [1:0] m_state;

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 3; i++) m_cnt[i] = 0;
        m_y = 0; m_vld = 0; m_mis = 0; m_err = 0; m_fault = 3'b000; m_state = 2'b00;
    endtask

    task automatic model_step(input logic e, input logic ba, input logic bb, input logic bc, input logic clr);
        logic [2:0] chv;
        int ones, n;
        logic s0, s1;
        chv = {ba, bb, bc};
        m_vld = 0;
        if (clr) begin
            for (int i = 0; i < 3; i++) m_cnt[i] = 0;
            m_fault = 3'b000; m_err = 0; m_mis = 0; m_state = 2'b00;
        end else if (e && m_state == 2'b00) begin
            ones  = int'(ba) + int'(bb) + int'(bc);
            m_y   = (ones >= 2);
            m_vld = 1;
            m_mis = (ones == 1 || ones == 2);
            for (int i = 0; i < 3; i++) begin
                if (m_mis && chv[2-i] != m_y) begin
                    if (m_cnt[i] < THRESH) m_cnt[i]++;
                    if (m_cnt[i] == THRESH) begin
                        m_fault = m_fault | (3'b100 >> i);
                        m_state = 2'b01;
                    end
                end else begin
                    m_cnt[i] = 0;
                end
            end
        end else if (e && m_state == 2'b01) begin
            n = 0; s0 = 0; s1 = 0;
            for (int i = 0; i < 3; i++) begin
                if (!m_fault[2-i]) begin
                    if (n == 0) s0 = chv[2-i];
                    else        s1 = chv[2-i];
                    n++;
                end
            end
            if (s0 == s1) begin
                m_y = s0; m_vld = 1; m_mis = 0;
            end else begin
                m_mis = 1; m_err = 1; m_state = 2'b10;
            end
        end
    endtask

    task automatic check_outputs(input string tag, input exp_t ex);
        check($sformatf("%s y", tag),        {7'd0, y},        {7'd0, ex.y});
        check($sformatf("%s y_valid", tag),  {7'd0, y_valid},  {7'd0, ex.vld});
        check($sformatf("%s mismatch", tag), {7'd0, mismatch}, {7'd0, ex.mis});
        check($sformatf("%s fault", tag),    {5'd0, fault},    {5'd0, ex.fault});
        check($sformatf("%s state", tag),    {6'd0, state},    {6'd0, ex.st});
        check($sformatf("%s err", tag),      {7'd0, err},      {7'd0, ex.err});
    endtask

    task automatic step(input logic e, input logic ba, input logic bb, input logic bc, input logic clr);
        exp_t ex;
        @(negedge clk);
        en = e; a = ba; b = bb; c = bc; clr_fault = clr;
        model_step(e, ba, bb, bc, clr);
        sb_q.push_back('{y: m_y, vld: m_vld, mis: m_mis, fault: m_fault, st: m_state, err: m_err});
        @(posedge clk);
        #1;
        n_step++;
        if (sb_q.size() == 0) begin
            check("scoreboard empty", 8'd1, 8'd0);
        end else begin
            ex = sb_q.pop_front();
            check_outputs($sformatf("step%0d", n_step), ex);
        end
    endtask

    initial begin
        exp_t rst_ex;
        rst_ex = '0;
        reset = 1'b1; en = 0; a = 0; b = 0; c = 0; clr_fault = 0;
        model_reset();
        #1;
        check_outputs("reset", rst_ex);
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;

        // All agree
        step(1, 1, 1, 1, 0);
        // a minority THRESH times -> a retired
        repeat (THRESH) step(1, 0, 1, 1, 0);
        check("a_retired fault", {5'd0, fault}, 8'h04);
        // Degraded vote, then survivors split
        step(1, 0, 1, 1, 0);
        step(0, 0, 0, 0, 0);
        step(1, 1, 1, 0, 0);
        check("failed state", {6'd0, state}, 8'h02);
        step(1, 1, 1, 1, 0);
        step(1, 0, 0, 0, 0);
        // clr_fault wins over same-cycle en
        step(1, 0, 0, 0, 1);
        step(1, 0, 0, 0, 0);
        // Minority run broken by an agreeing sample
        repeat (THRESH - 1) step(1, 1, 1, 0, 0);
        step(1, 1, 1, 1, 0);
        repeat (THRESH - 1) step(1, 1, 1, 0, 0);
        check("c_not_retired fault", {5'd0, fault}, 8'h00);
        step(0, 1, 1, 0, 0);
        step(1, 0, 0, 1, 0);
        check("c_retired fault", {5'd0, fault}, 8'h01);

        // Random traffic with occasional clears
        for (int i = 0; i < 120; i++) begin
            step(1'($urandom_range(0, 3) != 0), 1'($urandom), 1'($urandom), 1'($urandom),
                 1'($urandom_range(0, 15) == 0));
        end

        // Async reset mid-count on b
        step(0, 0, 0, 0, 1);
        step(1, 1, 0, 1, 0);
        step(1, 1, 0, 1, 0);
        @(negedge clk);
        en = 0;
        #2;
        reset = 1'b1;
        #1;
        model_reset();
        check_outputs("async_reset", rst_ex);
        @(negedge clk);
        reset = 1'b0;
        repeat (THRESH - 1) step(1, 1, 0, 1, 0);
        check("b_after_reset fault", {5'd0, fault}, 8'h00);
        check("b_after_reset state", {6'd0, state}, 8'h00);
        step(1, 1, 0, 1, 0);
        check("b_retired fault", {5'd0, fault}, 8'h02);

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end
endmodule
